// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and helpers for the 4-digit common-anode FND driver.
//   - Segment fonts for digits 0-9, ordered {dp,g,f,e,d,c,b,a}, active-low, dp off.
//   - Blank font and all-off select pattern used while in reset.
//   - Active-low one-hot select patterns for each digit index.
//   - Digit-index type plus lookup functions for font and select.
package fnd_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_BLANK = 8'hFF;

    localparam logic [3:0] SEL_OFF = 4'b1111;
    localparam logic [3:0] SEL_D0  = 4'b1110;
    localparam logic [3:0] SEL_D1  = 4'b1101;
    localparam logic [3:0] SEL_D2  = 4'b1011;
    localparam logic [3:0] SEL_D3  = 4'b0111;

    // BCD nibbles above 9 cannot occur from the splitter; they map to blank.
    function automatic logic [7:0] font_of(input logic [3:0] digit);
        logic [7:0] font;
        case (digit)
            4'd0:    font = FONT_0;
            4'd1:    font = FONT_1;
            4'd2:    font = FONT_2;
            4'd3:    font = FONT_3;
            4'd4:    font = FONT_4;
            4'd5:    font = FONT_5;
            4'd6:    font = FONT_6;
            4'd7:    font = FONT_7;
            4'd8:    font = FONT_8;
            4'd9:    font = FONT_9;
            default: font = FONT_BLANK;
        endcase
        return font;
    endfunction

    function automatic logic [3:0] sel_of(input digit_idx_t idx);
        logic [3:0] sel;
        case (idx)
            2'd0:    sel = SEL_D0;
            2'd1:    sel = SEL_D1;
            2'd2:    sel = SEL_D2;
            2'd3:    sel = SEL_D3;
            default: sel = SEL_OFF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/fnd_digit_splitter.sv
// fnd_digit_splitter: combinational 14-bit binary to four BCD digits.
//   bin_i         : unsigned value 0..16383
//   ones_o..thou_o: decimal digits; values above 9999 keep only the lower four digits.
module fnd_digit_splitter (
    input  logic [13:0] bin_i,
    output logic [3:0]  ones_o,
    output logic [3:0]  tens_o,
    output logic [3:0]  hund_o,
    output logic [3:0]  thou_o
);

    // Constant divide/modulo; synthesis reduces these to fixed arithmetic.
    always_comb begin
        ones_o = 4'(bin_i % 14'd10);
        tens_o = 4'((bin_i / 14'd10) % 14'd10);
        hund_o = 4'((bin_i / 14'd100) % 14'd10);
        thou_o = 4'((bin_i / 14'd1000) % 14'd10);
    end

endmodule

// File: rtl/top_time_watch.sv
// top_time_watch: time-multiplexed 4-digit common-anode FND driver.
//   sysclk      : system clock, rising edge
//   i_rst_n     : asynchronous reset, active-HIGH despite the name
//   i_fndData   : 14-bit value to display, sampled combinationally every cycle
//   o_fndSelect : active-low one-hot digit enable, bit 0 = ones digit (registered)
//   o_fndFont   : active-low segments {dp,g,f,e,d,c,b,a} (registered)
// Each digit is selected for SCAN_DIV cycles; the index advances on prescaler wrap
// and the registered outputs follow one cycle later.
module top_time_watch
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        sysclk,
    input  logic        i_rst_n,
    input  logic [13:0] i_fndData,
    output logic [3:0]  o_fndSelect,
    output logic [7:0]  o_fndFont
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [3:0]    sel_q, sel_d;
    logic [7:0]    font_q, font_d;
    logic [3:0]    ones_s, tens_s, hund_s, thou_s;
    logic [3:0]    digit_s;

    fnd_digit_splitter u_splitter (
        .bin_i  (i_fndData),
        .ones_o (ones_s),
        .tens_o (tens_s),
        .hund_o (hund_s),
        .thou_o (thou_s)
    );

    // Next-state: prescaler, digit index, and select/font for the current index.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        digit_s = ones_s;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CW{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
        end
        case (idx_q)
            2'd0:    digit_s = ones_s;
            2'd1:    digit_s = tens_s;
            2'd2:    digit_s = hund_s;
            2'd3:    digit_s = thou_s;
            default: digit_s = ones_s;
        endcase
        // Select and font are derived from the same index so they never disagree.
        sel_d  = sel_of(idx_q);
        font_d = font_of(digit_s);
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge sysclk or posedge i_rst_n) begin
        if (i_rst_n) begin
            cnt_q  <= {CW{1'b0}};
            idx_q  <= 2'd0;
            sel_q  <= SEL_OFF;
            font_q <= FONT_BLANK;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            font_q <= font_d;
        end
    end

    assign o_fndSelect = sel_q;
    assign o_fndFont   = font_q;

endmodule

// File: tb/tb_top_time_watch.sv
// Self-checking bench for top_time_watch with SCAN_DIV = 4.
// Reference: after reset release, edge k (k >= 1) shows digit ((k-1)/SCAN)%4 of the
// value present just before that edge, computed with plain decimal arithmetic.
module tb_top_time_watch;

    localparam int SCAN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] data = 14'd0;
    logic [3:0]  sel;
    logic [7:0]  font;

    int tests = 0;
    int fails = 0;
    int k     = 0;

    logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int         pow10    [4]  = '{1, 10, 100, 1000};

    typedef struct {
        logic [13:0] value;
        int          pos;
        logic [3:0]  exp_sel;
        logic [7:0]  exp_font;
    } vec_t;

    vec_t vecs [12];

    top_time_watch #(.SCAN_DIV(SCAN)) dut (
        .sysclk      (clk),
        .i_rst_n     (rst),
        .i_fndData   (data),
        .o_fndSelect (sel),
        .o_fndFont   (font)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] es, input logic [7:0] ef);
        tests++;
        if (sel !== es || font !== ef) begin
            fails++;
            $display("FAIL %s: got sel=%b font=%h, want sel=%b font=%h (t=%0t)",
                     name, sel, font, es, ef, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Assert reset between edges, check blanking before any edge, then release.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_async", 4'b1111, 8'hFF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
    endtask

    function automatic int model_idx(input int kk);
        return ((kk - 1) / SCAN) % 4;
    endfunction

    function automatic logic [3:0] model_sel(input int kk);
        logic [3:0] s;
        s = 4'b1111;
        s[model_idx(kk)] = 1'b0;
        return s;
    endfunction

    function automatic logic [7:0] model_font(input int v, input int kk);
        return font_tab[(v / pow10[model_idx(kk)]) % 10];
    endfunction

    task automatic chk_model(input string name);
        chk(name, model_sel(k), model_font(int'(data), k));
    endtask

    initial begin
        // Table: {value, digit position, expected select, expected font}.
        vecs[0]  = '{14'd1234,  0, 4'b1110, 8'h99};
        vecs[1]  = '{14'd1234,  1, 4'b1101, 8'hB0};
        vecs[2]  = '{14'd1234,  2, 4'b1011, 8'hA4};
        vecs[3]  = '{14'd1234,  3, 4'b0111, 8'hF9};
        vecs[4]  = '{14'd42,    0, 4'b1110, 8'hA4};
        vecs[5]  = '{14'd42,    1, 4'b1101, 8'h99};
        vecs[6]  = '{14'd42,    2, 4'b1011, 8'hC0};
        vecs[7]  = '{14'd42,    3, 4'b0111, 8'hC0};
        vecs[8]  = '{14'd16383, 0, 4'b1110, 8'hB0};
        vecs[9]  = '{14'd16383, 1, 4'b1101, 8'h80};
        vecs[10] = '{14'd16383, 2, 4'b1011, 8'hB0};
        vecs[11] = '{14'd16383, 3, 4'b0111, 8'h82};

        // Reset held for 100 cycles with 1234 on the input.
        #2;
        data = 14'd1234;
        rst  = 1'b1;
        #1;
        chk("reset_initial", 4'b1111, 8'hFF);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", 4'b1111, 8'hFF);
        end
        rst = 1'b0;
        k = 0;

        // Full scan of 1234 plus wrap back to the ones digit.
        for (int i = 0; i < 4 * SCAN + 2; i++) begin
            step();
            chk_model("scan_1234");
        end

        // Table-driven digit checks: first edge of each digit's dwell.
        foreach (vecs[i]) begin
            data = vecs[i].value;
            do_reset();
            for (int e = 0; e < vecs[i].pos * SCAN + 1; e++) step();
            chk("table_digit", vecs[i].exp_sel, vecs[i].exp_font);
        end

        // Mid-frame change to 8888 shows on the active digit at the next edge.
        data = 14'd1234;
        do_reset();
        for (int e = 0; e < SCAN + 2; e++) step();
        data = 14'd8888;
        step();
        chk("change_next_edge", 4'b1101, 8'h80);
        for (int e = 0; e < 4 * SCAN; e++) begin
            step();
            chk_model("change_frame");
        end

        // Reset during index 2 blanks at once; scan restarts with full ones dwell.
        data = 14'd1234;
        do_reset();
        for (int e = 0; e < 2 * SCAN + 2; e++) step();
        chk("pre_midreset_idx2", 4'b1011, 8'hA4);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_async", 4'b1111, 8'hFF);
        @(posedge clk);
        #1;
        chk("midreset_hold", 4'b1111, 8'hFF);
        rst = 1'b0;
        k = 0;
        for (int e = 0; e < SCAN; e++) begin
            step();
            chk("restart_ones", 4'b1110, 8'h99);
        end
        step();
        chk("restart_tens", 4'b1101, 8'hB0);

        // Randomized values checked against the arithmetic reference.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) data = 14'($urandom_range(0, 16383));
            step();
            chk_model("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule

// File: doc/top_time_watch.md
# top_time_watch

4-digit, 7-segment (FND) display driver. It takes a 14-bit binary value, splits it into four decimal digits, and time-multiplexes them onto a common-anode 4-digit display: one active-low digit select and one active-low segment font. It sits at the board top level, between the value source and the FND pins.

## Interface
- `SCAN_DIV`, 100_000: clock cycles each digit stays selected (1 ms at 100 MHz). Legal range is ≥ 2.
- `sysclk` input, 1 bit: system clock; all state changes on the rising edge.
- `i_rst_n` input, 1 bit: reset, asynchronous, active-high. The name is the codebase's; the polarity is fixed high.
- `i_fndData` input, 14 bits: unsigned binary value to display, range 0–16383.
- `o_fndSelect` output, 4 bits: digit enables, active-low one-hot. Bit 0 is the ones digit, bit 3 the thousands digit.
- `o_fndFont` output, 8 bits: segments `{dp,g,f,e,d,c,b,a}`, active-low.

## Operation
- Digit split:
  - ones = v%10, tens = (v/10)%10, hundreds = (v/100)%10, thousands = (v/1000)%10.
  - Values above 9999 therefore show their lower four decimal digits; 12345 displays "2345".
  - No leading-zero blanking: 42 displays "0042".
- Prescaler: a counter runs 0..SCAN_DIV-1 and wraps. On wrap, a 2-bit digit index advances 0→1→2→3→0.
- Select pattern per index:
  - 0 → 4'b1110
  - 1 → 4'b1101
  - 2 → 4'b1011
  - 3 → 4'b0111
- Font per digit value (dp = 1, i.e. off):
  - 0 = 8'hC0, 1 = 8'hF9, 2 = 8'hA4, 3 = 8'hB0, 4 = 8'h99
  - 5 = 8'h92, 6 = 8'h82, 7 = 8'hF8, 8 = 8'h80, 9 = 8'h90
- Both outputs are registered and update on the same edge. Select and font never disagree for a cycle.
- `i_fndData` is used combinationally each cycle; there is no input latch.

## Timing
- While reset is high:
  - prescaler = 0, index = 0
  - `o_fndSelect` = 4'b1111 (all off), `o_fndFont` = 8'hFF (blank)
  - All of these take effect immediately, without waiting for a clock edge.
- First rising edge after reset deasserts: `o_fndSelect` = 4'b1110 and `o_fndFont` = font(ones digit).
- Each digit stays selected exactly SCAN_DIV cycles. A full frame is 4×SCAN_DIV cycles.
- The index changes on the edge where the prescaler wraps; the registered outputs reflect the new index one cycle later.
- A change on `i_fndData` appears on the currently selected digit's font at the next rising edge (1-cycle latency). Other digits pick up the new value when they are next scanned.
- Reset asserted mid-frame blanks the outputs at once. After release the scan restarts at index 0 with the prescaler at 0.
- Index wraps from 3 to 0 with no gap cycle.

## Structure
- Shared package `fnd_pkg`:
  - the 10 font constants
  - the blank font (8'hFF) and all-off select (4'b1111)
  - the four select patterns
  - the digit-index type (2-bit)
- One sub-module, `fnd_digit_splitter`: a combinational 14-bit binary to 4×4-bit BCD converter. Use double-dabble or constant divide/modulo; either is acceptable if it is combinational.
- The top module holds the prescaler, the index counter, the select/font mux and the output registers.

## Test plan
All scenarios use SCAN_DIV = 4.
- Reset: hold `i_rst_n` = 1 for 100 cycles with `i_fndData` = 1234 → select = 4'b1111 and font = 8'hFF throughout.
- Scan of 1234 after reset release → for 4 cycles each, in order:
  - 1110 / 8'h99 ("4")
  - 1101 / 8'hB0 ("3")
  - 1011 / 8'hA4 ("2")
  - 0111 / 8'hF9 ("1")
  - then back to 1110 / 8'h99.
- Change input to 8888 mid-frame → from the next edge, the active digit shows 8'h80, and every digit shows 8'h80 within one frame.
- Value 42 → digits from ones to thousands show 8'hA4, 8'h99, 8'hC0, 8'hC0 (leading zeros shown).
- Value 16383 → digits from ones to thousands show 3, 8, 3, 6, i.e. 8'hB0, 8'h80, 8'hB0, 8'h82.
- Assert reset during digit index 2 → outputs go to 1111 / FF immediately, without a clock edge. After release the scan restarts at the ones digit with a full SCAN_DIV dwell.
